if_prefetch_unit: RTL and testbench



---
 rtl/if_prefetch_unit_if.sv | 27 ++
 rtl/if_prefetch_unit.sv | 154 +++++++++++++++
 tb/tb_if_prefetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - instruction bus between the prefetch unit and instruction memory
interface if_prefetch_unit_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        instr_valid;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rdata,
        input  instr_err,
        input  instr_valid
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rdata,
        output instr_err,
        output instr_valid
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - pipelined instruction prefetch with response FIFO and 16/32-bit realignment
module if_prefetch_unit #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        boot_addr,
    input  logic               fetch_enable,
    input  logic               branch_valid,
    input  logic [31:0]        branch_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic               out_is_compress,
    output logic               out_err,
    if_prefetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [CW-1:0] cnt_t;

    logic [32:0]   fifo_q [DEPTH];
    cnt_t          outstanding_q, outstanding_d;
    cnt_t          discard_q, discard_d;
    cnt_t          count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   pc_q, pc_d;
    logic          pending_q, pending_d;

    logic          room, req, grant, live, drop, push, pop, accept;
    logic [31:0]   req_addr;
    logic [PW-1:0] rd_ptr_nx;
    logic [32:0]   w0;
    logic [15:0]   w1_lo;
    logic          w1_err;
    logic [31:0]   al_instr;
    logic          al_err, al_avail, al_pop, al_half;

    // Discarded responses still occupy bus slots, so they count against the in-flight limit.
    assign room = (int'(outstanding_q) + int'(discard_q) < MAX_OUTSTANDING)
               && (int'(count_q) + int'(outstanding_q) < DEPTH);
    assign req      = (pending_q && !branch_valid) || (fetch_enable && room);
    assign req_addr = branch_valid ? (branch_addr & 32'hFFFF_FFFC) : fetch_addr_q;
    assign grant    = req && bus.instr_gnt;

    assign bus.instr_req  = req;
    assign bus.instr_addr = req_addr;

    assign drop = bus.instr_valid && (discard_q != '0);
    assign live = bus.instr_valid && (discard_q == '0) && (outstanding_q != '0);
    assign push = live && !branch_valid;

    assign rd_ptr_nx = rd_ptr_q + PW'(1);
    assign w0        = fifo_q[rd_ptr_q];
    assign w1_lo     = fifo_q[rd_ptr_nx][15:0];
    assign w1_err    = fifo_q[rd_ptr_nx][32];

    always_comb begin
        al_instr = w0[31:0];
        al_err   = w0[32];
        al_avail = (count_q != '0);
        al_pop   = 1'b1;
        al_half  = 1'b0;
        if (!pc_q[1]) begin
            if (w0[1:0] != 2'b11) begin
                al_instr = {16'h0000, w0[15:0]};
                al_pop   = 1'b0;
                al_half  = 1'b1;
            end
        end else if (w0[17:16] != 2'b11) begin
            al_instr = {16'h0000, w0[31:16]};
            al_half  = 1'b1;
        end else begin
            // 32-bit instruction straddling two words needs both in the FIFO.
            al_instr = {w1_lo, w0[31:16]};
            al_err   = w0[32] | w1_err;
            al_avail = (count_q > cnt_t'(1));
        end
    end

    assign out_valid       = al_avail && !branch_valid;
    assign accept          = out_valid && out_ready;
    assign pop             = accept && al_pop;
    assign out_instr       = al_instr;
    assign out_pc          = pc_q;
    assign out_is_compress = (al_instr[1:0] != 2'b11);
    assign out_err         = al_err;

    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        pc_d          = pc_q;
        pending_d     = req && !grant;
        fetch_addr_d  = grant ? (req_addr + 32'd4) : req_addr;
        if (branch_valid) begin
            // Everything still owed to the old stream becomes discard; a same-cycle grant is new-stream.
            discard_d     = discard_q - cnt_t'(drop) + outstanding_q - cnt_t'(live);
            outstanding_d = cnt_t'(grant);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            pc_d          = branch_addr & 32'hFFFF_FFFE;
        end else begin
            discard_d     = discard_q - cnt_t'(drop);
            outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(live);
            count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_nx;
            end
            if (accept) begin
                pc_d = pc_q + (al_half ? 32'd2 : 32'd4);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pending_q     <= 1'b0;
            pc_q          <= boot_addr;
            fetch_addr_q  <= boot_addr & 32'hFFFF_FFFC;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pending_q     <= pending_d;
            pc_q          <= pc_d;
            fetch_addr_q  <= fetch_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {bus.instr_err, bus.instr_rdata};
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed table-driven bench for if_prefetch_unit
module tb_if_prefetch_unit;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        reset_n, fetch_enable, branch_valid, out_ready;
    logic [31:0] boot_addr, branch_addr;
    logic        out_valid, out_is_compress, out_err;
    logic [31:0] out_instr, out_pc;

    if_prefetch_unit_if bus ();

    if_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n), .boot_addr(boot_addr), .fetch_enable(fetch_enable),
        .branch_valid(branch_valid), .branch_addr(branch_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_is_compress(out_is_compress), .out_err(out_err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int scn; logic [31:0] addr; logic [31:0] word; logic err; } img_t;
    typedef struct { int scn; logic [31:0] pc; logic [31:0] instr; logic comp; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic comp; logic err; int cyc; } acc_t;

    img_t        img_tab [$];
    exp_t        exp_tab [$];
    req_t        rq [$];
    acc_t        acc [$];
    logic [31:0] mem_word [logic [31:0]];
    logic        mem_err  [logic [31:0]];

    int   total = 0, bad = 0;
    int   cyc = 0, lat = 1, epoch = 0, new_delivered = 0, nd_first = -1;
    int   valid_cnt = 0, grants = 0, max_inflight = 0;
    logic gnt_alt = 1'b0, seen_valid = 1'b0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_image(input int scn);
        mem_word.delete();
        mem_err.delete();
        foreach (img_tab[i]) begin
            if (img_tab[i].scn == scn) begin
                mem_word[img_tab[i].addr] = img_tab[i].word;
                mem_err[img_tab[i].addr]  = img_tab[i].err;
            end
        end
    endtask

    task automatic do_reset(input logic [31:0] boot);
        reset_n = 1'b0; boot_addr = boot; fetch_enable = 1'b0;
        branch_valid = 1'b0; branch_addr = '0; out_ready = 1'b1; gnt_alt = 1'b0;
        bus.instr_gnt = 1'b0; bus.instr_valid = 1'b0; bus.instr_rdata = '0; bus.instr_err = 1'b0;
        rq.delete();
        acc.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock cycle, entered at a falling edge: drive, settle, sample, advance.
    task automatic cycle(input logic br, input logic [31:0] br_addr);
        req_t r;
        int   nd_before;
        branch_valid = br;
        branch_addr  = br_addr;
        if (br) epoch++;
        nd_before = new_delivered;
        bus.instr_valid = 1'b0; bus.instr_rdata = '0; bus.instr_err = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            bus.instr_valid = 1'b1;
            bus.instr_rdata = mem_word.exists(r.addr) ? mem_word[r.addr] : dflt(r.addr);
            bus.instr_err   = mem_err.exists(r.addr) ? mem_err[r.addr] : 1'b0;
            if (r.epoch == epoch) new_delivered++;
        end
        bus.instr_gnt = gnt_alt ? ((cyc % 2) == 0) : 1'b1;
        #1;
        if (out_valid) valid_cnt++;
        if (out_valid && !seen_valid) begin
            seen_valid = 1'b1;
            nd_first   = nd_before;
        end
        if (out_valid && out_ready) acc.push_back('{out_pc, out_instr, out_is_compress, out_err, cyc});
        if (bus.instr_req && bus.instr_gnt) begin
            rq.push_back('{bus.instr_addr, cyc + lat, epoch});
            grants++;
        end
        if (rq.size() > max_inflight) max_inflight = rq.size();
        @(negedge clk);
        cyc++;
    endtask

    task automatic compare_scn(input int scn, input string tag);
        int k = 0;
        foreach (exp_tab[i]) begin
            if (exp_tab[i].scn == scn) begin
                if (k < acc.size()) begin
                    check($sformatf("%s[%0d].pc", tag, k), acc[k].pc, exp_tab[i].pc);
                    check($sformatf("%s[%0d].instr", tag, k), acc[k].instr, exp_tab[i].instr);
                    check($sformatf("%s[%0d].comp", tag, k), 32'(acc[k].comp), 32'(exp_tab[i].comp));
                    check($sformatf("%s[%0d].err", tag, k), 32'(acc[k].err), 32'(exp_tab[i].err));
                end else begin
                    check($sformatf("%s[%0d].present", tag, k), 32'(acc.size()), 32'(k + 1));
                end
                k++;
            end
        end
    endtask

    initial begin
        img_tab.push_back('{2, 32'h080, 32'h0001_4501, 1'b0});
        img_tab.push_back('{2, 32'h084, 32'h0013_0093, 1'b0});
        img_tab.push_back('{3, 32'h100, 32'h0093_6F01, 1'b0});
        img_tab.push_back('{3, 32'h104, 32'h4505_0513, 1'b0});
        img_tab.push_back('{6, 32'h100, 32'h0093_4501, 1'b0});
        img_tab.push_back('{6, 32'h104, 32'h4505_0513, 1'b1});

        for (int i = 0; i < 8; i++)
            exp_tab.push_back('{1, 32'h80 + 32'(4 * i), dflt(32'h80 + 32'(4 * i)), 1'b0, 1'b0});
        exp_tab.push_back('{2, 32'h080, 32'h0000_4501, 1'b1, 1'b0});
        exp_tab.push_back('{2, 32'h082, 32'h0000_0001, 1'b1, 1'b0});
        exp_tab.push_back('{2, 32'h084, 32'h0013_0093, 1'b0, 1'b0});
        exp_tab.push_back('{2, 32'h088, 32'h0000_8813, 1'b0, 1'b0});
        exp_tab.push_back('{3, 32'h102, 32'h0513_0093, 1'b0, 1'b0});
        exp_tab.push_back('{3, 32'h106, 32'h0000_4505, 1'b1, 1'b0});
        exp_tab.push_back('{3, 32'h108, 32'h0001_0813, 1'b0, 1'b0});
        exp_tab.push_back('{4, 32'h200, 32'h0002_0013, 1'b0, 1'b0});
        exp_tab.push_back('{4, 32'h204, 32'h0002_0413, 1'b0, 1'b0});
        exp_tab.push_back('{4, 32'h208, 32'h0002_0813, 1'b0, 1'b0});
        exp_tab.push_back('{6, 32'h100, 32'h0000_4501, 1'b1, 1'b0});
        exp_tab.push_back('{6, 32'h102, 32'h0513_0093, 1'b0, 1'b1});
        exp_tab.push_back('{6, 32'h106, 32'h0000_4505, 1'b1, 1'b1});
        exp_tab.push_back('{6, 32'h108, 32'h0001_0813, 1'b0, 1'b0});

        // Reset state with an unaligned boot address.
        do_reset(32'h86);
        #1;
        check("rst.instr_req", 32'(bus.instr_req), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_pc", out_pc, 32'h86);
        check("rst.instr_addr", bus.instr_addr, 32'h84);

        // Straight-line 32-bit code, single-cycle memory.
        do_reset(32'h80); load_image(1); lat = 1; max_inflight = 0;
        fetch_enable = 1'b1;
        repeat (20) cycle(1'b0, '0);
        compare_scn(1, "seq");
        for (int i = 0; i < 7 && i + 1 < acc.size(); i++)
            check($sformatf("seq.b2b[%0d]", i), 32'(acc[i + 1].cyc - acc[i].cyc), 32'd1);
        check("seq.max_inflight_ok", 32'(max_inflight <= MAXO), 32'd1);

        // Mixed compressed / 32-bit words.
        do_reset(32'h80); load_image(2); lat = 1;
        fetch_enable = 1'b1;
        repeat (20) cycle(1'b0, '0);
        compare_scn(2, "mix");

        // Branch to unaligned 32-bit instruction; words arrive two cycles apart.
        do_reset(32'h80); load_image(3); lat = 3; gnt_alt = 1'b1;
        fetch_enable = 1'b1;
        repeat (6) cycle(1'b0, '0);
        acc.delete();
        new_delivered = 0;
        cycle(1'b1, 32'h103);
        seen_valid = 1'b0; nd_first = -1;
        repeat (30) cycle(1'b0, '0);
        compare_scn(3, "unal");
        check("unal.two_words_before_valid", 32'(nd_first >= 2), 32'd1);

        // Branch with two responses outstanding, 3-cycle latency.
        do_reset(32'h80); load_image(4); lat = 3;
        fetch_enable = 1'b1;
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        check("flush.inflight_at_branch", 32'(rq.size()), 32'd2);
        acc.delete();
        cycle(1'b1, 32'h200);
        repeat (30) cycle(1'b0, '0);
        compare_scn(4, "flush");

        // Decode stall: FIFO fills to DEPTH then requests stop.
        do_reset(32'h80); load_image(5); lat = 1;
        fetch_enable = 1'b1; out_ready = 1'b0; grants = 0;
        repeat (6) cycle(1'b0, '0);
        check("stall.out_valid", 32'(out_valid), 32'd1);
        check("stall.pc_mid", out_pc, 32'h80);
        repeat (4) cycle(1'b0, '0);
        check("stall.grants", 32'(grants), 32'(DEPTH));
        check("stall.instr_req", 32'(bus.instr_req), 32'd0);
        check("stall.pc_end", out_pc, 32'h80);
        check("stall.instr_end", out_instr, dflt(32'h80));
        out_ready = 1'b1;
        repeat (20) cycle(1'b0, '0);
        compare_scn(1, "drain");

        // Bus error on the second word of a straddling instruction.
        do_reset(32'h100); load_image(6); lat = 2;
        fetch_enable = 1'b1;
        repeat (20) cycle(1'b0, '0);
        compare_scn(6, "err");

        // Reset with requests in flight; stray responses afterwards must be ignored.
        do_reset(32'h80); load_image(7); lat = 4;
        fetch_enable = 1'b1;
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        reset_n = 1'b0; boot_addr = 32'h300; fetch_enable = 1'b0;
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        reset_n = 1'b1; valid_cnt = 0;
        repeat (6) cycle(1'b0, '0);
        check("stray.valid_cnt", 32'(valid_cnt), 32'd0);
        check("stray.out_pc", out_pc, 32'h300);
        check("stray.instr_req", 32'(bus.instr_req), 32'd0);

        check("all.max_inflight_ok", 32'(max_inflight <= MAXO), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
